// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core's AXI4-Lite master path.
//   bus_state_t      - sequencer state encoding
//   AXI_RESP_*       - AXI response codes
//   AXI_PROT_DATA    - protection attribute driven on AW/AR
//   axi_resp_is_err  - true for SLVERR and DECERR
package core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_RESP
   } bus_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_PROT_DATA   = 3'b000;

   // SLVERR and DECERR both have the upper bit set; OKAY/EXOKAY do not.
   function automatic logic axi_resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: per-transaction wait counter for axi_lite_bus_ctrl.
// Only instantiated when AXI_TIMEOUT_EN is defined.
//   clk, reset    - clock, async active-low reset
//   i_clr         - restart count (transaction accepted)
//   i_en          - count this cycle (transaction waiting on the slave)
//   o_expired     - this enabled cycle is the LIMIT-th waiting cycle
module bus_timeout_ctr #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] r_count;

   // Expiry is flagged in the cycle the count would reach LIMIT, so the
   // slave gets exactly LIMIT waiting cycles before the sequencer gives up.
   assign o_expired = i_en && (r_count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/axi_lite_bus_ctrl.sv
// axi_lite_bus_ctrl: runs one AXI4-Lite transaction at a time for the core's
// load/store valid/ready requester and returns a one-cycle response pulse.
//   clk, reset                 - clock, async active-low reset
//   req_*                      - requester side (valid/ready, we, addr, wdata, wstrb)
//   rsp_valid/rsp_rdata/rsp_err - response pulse, read data (0 for writes), error
//   m_axi_aw*/w*/b*/ar*/r*     - AXI4-Lite master port
// Optional: AXI_TIMEOUT_EN adds a TIMEOUT_CYCLES wait limit per transaction.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | ready for a request
// ST_WR_REQ  | AW and W outstanding, each drops after its own handshake
// ST_WR_RESP | waiting for B
// ST_RD_REQ  | AR outstanding
// ST_RD_RESP | waiting for R
// ST_RESP    | one-cycle response pulse to the requester
module axi_lite_bus_ctrl
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   input  logic [1:0]  m_axi_bresp,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp
);

   bus_state_t  r_state;
   bus_state_t  w_state_nxt;
   logic        r_aw_done;
   logic        r_w_done;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_timeout;

   assign w_accept = (r_state == ST_IDLE) && req_valid;
   assign w_aw_hs  = m_axi_awvalid && m_axi_awready;
   assign w_w_hs   = m_axi_wvalid && m_axi_wready;

`ifdef AXI_TIMEOUT_EN
   logic w_waiting;
   assign w_waiting = (r_state != ST_IDLE) && (r_state != ST_RESP);

   bus_timeout_ctr #(
      .LIMIT     (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_accept),
      .i_en      (w_waiting),
      .o_expired (w_timeout)
   );
`else
   localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   // Handshake-facing outputs decode straight from state so an async reset
   // drops them in the same instant.
   assign req_ready     = (r_state == ST_IDLE);
   assign m_axi_awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
   assign m_axi_wvalid  = (r_state == ST_WR_REQ) && !r_w_done;
   assign m_axi_bready  = (r_state == ST_WR_RESP);
   assign m_axi_arvalid = (r_state == ST_RD_REQ);
   assign m_axi_rready  = (r_state == ST_RD_RESP);
   assign rsp_valid     = (r_state == ST_RESP);

   // One address register serves both AW and AR; only one channel is live.
   assign m_axi_awaddr  = r_addr;
   assign m_axi_araddr  = r_addr;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_awprot  = AXI_PROT_DATA;
   assign m_axi_arprot  = AXI_PROT_DATA;
   assign rsp_rdata     = r_rdata;
   assign rsp_err       = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_nxt = req_we ? ST_WR_REQ : ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_state_nxt = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (m_axi_bvalid) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RD_REQ: begin
            if (m_axi_arready) begin
               w_state_nxt = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (m_axi_rvalid) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Giving up on an absent slave overrides any pending handshake.
      if (w_timeout) begin
         w_state_nxt = ST_RESP;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_aw_hs) begin
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_w_done <= 1'b1;
         end
         if ((r_state == ST_WR_RESP) && m_axi_bvalid) begin
            r_err <= axi_resp_is_err(m_axi_bresp);
         end
         if ((r_state == ST_RD_RESP) && m_axi_rvalid) begin
            r_rdata <= m_axi_rdata;
            r_err   <= axi_resp_is_err(m_axi_rresp);
         end
         if (w_timeout) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_bus_ctrl.sv
// tb_axi_lite_bus_ctrl: directed bench for axi_lite_bus_ctrl. The bench plays
// the AXI slave cycle by cycle; inputs change and outputs are checked on the
// falling edge. Define AXI_TIMEOUT_EN to include the timeout scenario.
module tb_axi_lite_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        m_axi_awvalid, m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid, m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;

   int n_cmp = 0;
   int n_err = 0;
   int n_rsp = 0;

   always #5 clk = ~clk;

   axi_lite_bus_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wstrb     (req_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp)
   );

   // Response pulses seen over the whole run.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) n_rsp++;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;

      // Reset values
      step(); step();
      chk1 ("rst_req_ready", req_ready, 1'b1);
      chk1 ("rst_awvalid", m_axi_awvalid, 1'b0);
      chk1 ("rst_wvalid", m_axi_wvalid, 1'b0);
      chk1 ("rst_bready", m_axi_bready, 1'b0);
      chk1 ("rst_arvalid", m_axi_arvalid, 1'b0);
      chk1 ("rst_rready", m_axi_rready, 1'b0);
      chk32("rst_awaddr", m_axi_awaddr, 32'h0);
      chk32("rst_wdata", m_axi_wdata, 32'h0);
      chk32("rst_wstrb", {28'h0, m_axi_wstrb}, 32'h0);
      chk32("rst_prot", {26'h0, m_axi_awprot, m_axi_arprot}, 32'h0);
      chk1 ("rst_rsp_valid", rsp_valid, 1'b0);
      chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk1 ("rst_rsp_err", rsp_err, 1'b0);
      reset = 1'b1;
      step();

      // T1: write, zero-wait slave
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1000;
      req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
      chk1 ("t1_c0_req_ready", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
      chk1 ("t1_c1_awvalid", m_axi_awvalid, 1'b1);
      chk1 ("t1_c1_wvalid", m_axi_wvalid, 1'b1);
      chk32("t1_c1_awaddr", m_axi_awaddr, 32'h0000_1000);
      chk32("t1_c1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
      chk32("t1_c1_wstrb", {28'h0, m_axi_wstrb}, 32'hF);
      chk1 ("t1_c1_req_ready", req_ready, 1'b0);
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      step();
      chk1 ("t1_c2_awvalid", m_axi_awvalid, 1'b0);
      chk1 ("t1_c2_wvalid", m_axi_wvalid, 1'b0);
      chk1 ("t1_c2_bready", m_axi_bready, 1'b1);
      chk1 ("t1_c2_rsp_valid", rsp_valid, 1'b0);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      step();
      chk1 ("t1_c3_rsp_valid", rsp_valid, 1'b1);
      chk1 ("t1_c3_rsp_err", rsp_err, 1'b0);
      chk32("t1_c3_rsp_rdata", rsp_rdata, 32'h0);
      chk1 ("t1_c3_bready", m_axi_bready, 1'b0);
      m_axi_bvalid = 1'b0;
      step();
      chk1 ("t1_c4_rsp_valid", rsp_valid, 1'b0);
      chk1 ("t1_c4_req_ready", req_ready, 1'b1);

      // Stray B/R while idle are not acknowledged
      m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hFFFF_FFFF;
      step();
      chk1 ("stray_bready", m_axi_bready, 1'b0);
      chk1 ("stray_rready", m_axi_rready, 1'b0);
      chk1 ("stray_rsp_valid", rsp_valid, 1'b0);
      m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
      step();

      // T2: awready delayed 3 cycles, wready immediate, DECERR response
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1100;
      req_wdata = 32'h0BAD_F00D; req_wstrb = 4'h3;
      step();
      req_valid = 1'b0;
      chk1 ("t2_c1_awvalid", m_axi_awvalid, 1'b1);
      chk1 ("t2_c1_wvalid", m_axi_wvalid, 1'b1);
      m_axi_wready = 1'b1;
      step();
      chk1 ("t2_c2_wvalid", m_axi_wvalid, 1'b0);
      chk1 ("t2_c2_awvalid", m_axi_awvalid, 1'b1);
      chk32("t2_c2_awaddr", m_axi_awaddr, 32'h0000_1100);
      m_axi_wready = 1'b0;
      step();
      chk1 ("t2_c3_awvalid", m_axi_awvalid, 1'b1);
      chk1 ("t2_c3_bready", m_axi_bready, 1'b0);
      chk32("t2_c3_awaddr", m_axi_awaddr, 32'h0000_1100);
      step();
      chk1 ("t2_c4_awvalid", m_axi_awvalid, 1'b1);
      chk1 ("t2_c4_wvalid", m_axi_wvalid, 1'b0);
      m_axi_awready = 1'b1;
      step();
      chk1 ("t2_c5_awvalid", m_axi_awvalid, 1'b0);
      chk1 ("t2_c5_bready", m_axi_bready, 1'b1);
      m_axi_awready = 1'b0;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
      step();
      chk1 ("t2_c6_rsp_valid", rsp_valid, 1'b1);
      chk1 ("t2_c6_rsp_err", rsp_err, 1'b1);
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      step();
      chk1 ("t2_c7_rsp_valid", rsp_valid, 1'b0);

      // T3: read 0x2004 returning SLVERR
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2004;
      step();
      req_valid = 1'b0;
      chk1 ("t3_c1_arvalid", m_axi_arvalid, 1'b1);
      chk32("t3_c1_araddr", m_axi_araddr, 32'h0000_2004);
      chk1 ("t3_c1_awvalid", m_axi_awvalid, 1'b0);
      m_axi_arready = 1'b1;
      step();
      chk1 ("t3_c2_arvalid", m_axi_arvalid, 1'b0);
      chk1 ("t3_c2_rready", m_axi_rready, 1'b1);
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b10;
      step();
      chk1 ("t3_c3_rsp_valid", rsp_valid, 1'b1);
      chk32("t3_c3_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk1 ("t3_c3_rsp_err", rsp_err, 1'b1);
      m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
      step();
      chk1 ("t3_c4_rsp_valid", rsp_valid, 1'b0);
      chk1 ("t3_c4_req_ready", req_ready, 1'b1);

      // T4: back-to-back read then write with req_valid held
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2100;
      step();
      chk1 ("t4_c1_req_ready", req_ready, 1'b0);
      chk1 ("t4_c1_arvalid", m_axi_arvalid, 1'b1);
      m_axi_arready = 1'b1;
      req_we = 1'b1; req_addr = 32'h0000_3000; req_wdata = 32'h55AA_33CC; req_wstrb = 4'b1001;
      step();
      chk1 ("t4_c2_req_ready", req_ready, 1'b0);
      chk1 ("t4_c2_rready", m_axi_rready, 1'b1);
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'hA5A5_0001; m_axi_rresp = 2'b00;
      step();
      chk1 ("t4_c3_rsp_valid", rsp_valid, 1'b1);
      chk32("t4_c3_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk1 ("t4_c3_rsp_err", rsp_err, 1'b0);
      chk1 ("t4_c3_req_ready", req_ready, 1'b0);
      m_axi_rvalid = 1'b0;
      step();
      chk1 ("t4_c4_req_ready", req_ready, 1'b1);
      chk1 ("t4_c4_rsp_valid", rsp_valid, 1'b0);
      step();
      req_valid = 1'b0;
      chk1 ("t4_c5_awvalid", m_axi_awvalid, 1'b1);
      chk32("t4_c5_awaddr", m_axi_awaddr, 32'h0000_3000);
      chk32("t4_c5_wdata", m_axi_wdata, 32'h55AA_33CC);
      chk32("t4_c5_wstrb", {28'h0, m_axi_wstrb}, 32'h9);
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      step();
      chk1 ("t4_c6_bready", m_axi_bready, 1'b1);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01;
      step();
      chk1 ("t4_c7_rsp_valid", rsp_valid, 1'b1);
      chk32("t4_c7_rsp_rdata", rsp_rdata, 32'h0);
      chk1 ("t4_c7_rsp_err", rsp_err, 1'b0);
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      step();

      // T5: reset asserted while waiting in RD_RESP
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2200;
      step();
      req_valid = 1'b0;
      m_axi_arready = 1'b1;
      step();
      chk1 ("t5_c2_rready", m_axi_rready, 1'b1);
      m_axi_arready = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk1 ("t5_rst_rready", m_axi_rready, 1'b0);
      chk1 ("t5_rst_arvalid", m_axi_arvalid, 1'b0);
      chk1 ("t5_rst_rsp_valid", rsp_valid, 1'b0);
      chk1 ("t5_rst_req_ready", req_ready, 1'b1);
      chk32("t5_rst_araddr", m_axi_araddr, 32'h0);
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'h7777_7777;
      step(); step();
      reset = 1'b1;
      m_axi_rvalid = 1'b0;
      step();
      chk1 ("t5_post_req_ready", req_ready, 1'b1);
      chk1 ("t5_post_rsp_valid", rsp_valid, 1'b0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
      step();
      req_valid = 1'b0;
      chk1 ("t5_rd_arvalid", m_axi_arvalid, 1'b1);
      chk32("t5_rd_araddr", m_axi_araddr, 32'h0000_0040);
      m_axi_arready = 1'b1;
      step();
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_F00D; m_axi_rresp = 2'b00;
      step();
      chk1 ("t5_rd_rsp_valid", rsp_valid, 1'b1);
      chk32("t5_rd_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      chk1 ("t5_rd_rsp_err", rsp_err, 1'b0);
      m_axi_rvalid = 1'b0;
      step();

`ifdef AXI_TIMEOUT_EN
      // T6: absent slave, arready never rises, limit 16
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5000;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         chk1 ("t6_arvalid_held", m_axi_arvalid, 1'b1);
         step();
      end
      chk1 ("t6_arvalid_dropped", m_axi_arvalid, 1'b0);
      chk1 ("t6_rsp_valid", rsp_valid, 1'b1);
      chk1 ("t6_rsp_err", rsp_err, 1'b1);
      chk32("t6_rsp_rdata", rsp_rdata, 32'h0);
      step();
      chk1 ("t6_req_ready", req_ready, 1'b1);
      step();
      chk32("rsp_pulse_count", n_rsp, 32'd7);
`else
      step();
      chk32("rsp_pulse_count", n_rsp, 32'd6);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
